// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
// Groups the handshake and bus signals of the instruction-fetch queue.
//   PC side     : pc_addr, redirect (to fetch), pc_stall (from fetch)
//   Memory side : imem_req_valid/imem_req_addr (from fetch), imem_req_ready,
//                 imem_rsp_valid, imem_rsp_data (to fetch)
//   Decode side : out_valid/out_addr/out_inst (from fetch), out_ready (to fetch)
// Optional macro FETCH_MISALIGN_CHECK_EN adds out_misalign (from fetch).
// Modports: master = the fetch queue, slave = its environment (PC/mem/decode).
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if #(
   parameter int AW = 32,
   parameter int IW = 32
);
   logic [AW-1:0] pc_addr;
   logic          redirect;
   logic          pc_stall;
   logic          imem_req_valid;
   logic [AW-1:0] imem_req_addr;
   logic          imem_req_ready;
   logic          imem_rsp_valid;
   logic [IW-1:0] imem_rsp_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [IW-1:0] out_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic          out_misalign;
`endif

   modport master (
      input  pc_addr, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             out_ready,
      output pc_stall, imem_req_valid, imem_req_addr, out_valid, out_addr,
             out_inst
`ifdef FETCH_MISALIGN_CHECK_EN
      , output out_misalign
`endif
   );

   modport slave (
      output pc_addr, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             out_ready,
      input  pc_stall, imem_req_valid, imem_req_addr, out_valid, out_addr,
             out_inst
`ifdef FETCH_MISALIGN_CHECK_EN
      , input out_misalign
`endif
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Fetch stage between the program counter and decode. Issues in-order reads
// to instruction memory for the current PC, pairs each returned word with its
// address and buffers the {addr, inst} pairs in a small FIFO for decode.
// The PC is held (pc_stall) unless a request is accepted; a branch redirect
// empties the FIFO and discards responses still in flight.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : inst_fetch_queue_if.master (PC, memory and decode handshakes)
// Optional macro FETCH_MISALIGN_CHECK_EN: a PC with addr[1:0] != 0 is not
// fetched; an entry {pc, 0, misalign=1} is queued instead (out_misalign).
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int INST_MEMORY_ADDRESS_WIDTH = 32,
   parameter int INST_WIDTH                = 32,
   parameter int QUEUE_DEPTH               = 4,
   parameter int MAX_OUTSTANDING           = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   inst_fetch_queue_if.master bus
);
   localparam int AW = INST_MEMORY_ADDRESS_WIDTH;
   localparam int IW = INST_WIDTH;
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int SW = CW + OW;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [CW-1:0] fifoCount_q, fifoCount_d;
   logic [OW-1:0] outstanding_q, outstanding_d;
   logic [OW-1:0] dropCnt_q, dropCnt_d;
   logic [QW-1:0] aqHead_q, aqHead_d, aqTail_q, aqTail_d;
   logic [AW-1:0] holdAddr_q, holdAddr_d;
   logic [IW-1:0] holdInst_q, holdInst_d;

   logic [AW-1:0] aqAddr_q   [MAX_OUTSTANDING];
   logic [AW-1:0] fifoAddr_q [QUEUE_DEPTH];
   logic [IW-1:0] fifoInst_q [QUEUE_DEPTH];

`ifdef FETCH_MISALIGN_CHECK_EN
   logic          fifoMis_q  [QUEUE_DEPTH];
   logic          holdMis_q, holdMis_d;
`endif

   logic          misalign, running, haveCredit;
   logic          reqValid, reqFire, rspPush, misPush, fifoPush, fifoPop;
   logic          fifoEmpty, pcStall;
   logic [AW-1:0] pushAddr;
   logic [IW-1:0] pushInst;
   logic [SW-1:0] occupancy;
   logic [OW-1:0] pending;

   // The address queue depth need not be a power of two, so wrap explicitly.
   function automatic logic [QW-1:0] aqNext(input logic [QW-1:0] p);
      if (p == QW'(MAX_OUTSTANDING - 1)) return '0;
      else                               return p + QW'(1);
   endfunction

   // Request/response qualification and PC back-pressure. A FIFO credit is
   // reserved for every request in flight so responses can always be pushed.
   // A misaligned entry is only queued once nothing is in flight, otherwise it
   // would overtake older fetches still on their way back from memory.
   always_comb begin
      misalign = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign = (bus.pc_addr[1:0] != 2'b00);
`endif
      fifoEmpty  = (fifoCount_q == '0);
      occupancy  = SW'(fifoCount_q) + SW'(outstanding_q);
      haveCredit = (occupancy < SW'(QUEUE_DEPTH));
      running    = rst_n && (state_q == RUN) && !bus.redirect;
      reqValid   = running && haveCredit && !misalign &&
                   (outstanding_q < OW'(MAX_OUTSTANDING));
      reqFire    = reqValid && bus.imem_req_ready;
      misPush    = running && misalign && haveCredit && (outstanding_q == '0);
      rspPush    = running && bus.imem_rsp_valid && (outstanding_q != '0);
      fifoPush   = rspPush || misPush;
      fifoPop    = !fifoEmpty && bus.out_ready && !bus.redirect;
      pushAddr   = misPush ? bus.pc_addr : aqAddr_q[aqHead_q];
      pushInst   = misPush ? '0 : bus.imem_rsp_data;

      if (!rst_n)                 pcStall = 1'b1;
      else if (bus.redirect)      pcStall = 1'b0;
      else if (state_q == FLUSH)  pcStall = 1'b1;
      else                        pcStall = !(reqFire || misPush);
   end

   // Next-state logic for the FSM, the address queue, the FIFO pointers and
   // the drop counter. In RUN drop_cnt is zero and in FLUSH nothing is
   // outstanding, so their sum is the number of responses still in flight.
   always_comb begin
      state_d       = state_q;
      dropCnt_d     = dropCnt_q;
      outstanding_d = outstanding_q;
      aqHead_d      = aqHead_q;
      aqTail_d      = aqTail_q;
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      fifoCount_d   = fifoCount_q;
      pending       = dropCnt_q + outstanding_q;

      if (bus.redirect) begin
         dropCnt_d     = (bus.imem_rsp_valid && pending != '0) ? pending - OW'(1) : pending;
         state_d       = (dropCnt_d != '0) ? FLUSH : RUN;
         outstanding_d = '0;
         aqHead_d      = '0;
         aqTail_d      = '0;
         wrPtr_d       = '0;
         rdPtr_d       = '0;
         fifoCount_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               outstanding_d = outstanding_q + OW'(reqFire) - OW'(rspPush);
               if (reqFire) aqTail_d = aqNext(aqTail_q);
               if (rspPush) aqHead_d = aqNext(aqHead_q);
            end
            FLUSH: begin
               if (dropCnt_q == '0) begin
                  state_d = RUN;
               end else if (bus.imem_rsp_valid) begin
                  dropCnt_d = dropCnt_q - OW'(1);
                  if (dropCnt_q == OW'(1)) state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
         if (fifoPush) wrPtr_d = wrPtr_q + PW'(1);
         if (fifoPop)  rdPtr_d = rdPtr_q + PW'(1);
         fifoCount_d = fifoCount_q + CW'(fifoPush) - CW'(fifoPop);
      end
   end

   // The hold registers track the head on display so an empty FIFO keeps
   // showing the last presented entry rather than a stale storage slot.
   always_comb begin
      holdAddr_d = fifoEmpty ? holdAddr_q : fifoAddr_q[rdPtr_q];
      holdInst_d = fifoEmpty ? holdInst_q : fifoInst_q[rdPtr_q];
`ifdef FETCH_MISALIGN_CHECK_EN
      holdMis_d  = fifoEmpty ? holdMis_q : fifoMis_q[rdPtr_q];
`endif
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         dropCnt_q     <= '0;
         outstanding_q <= '0;
         aqHead_q      <= '0;
         aqTail_q      <= '0;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         fifoCount_q   <= '0;
         holdAddr_q    <= '0;
         holdInst_q    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         holdMis_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         dropCnt_q     <= dropCnt_d;
         outstanding_q <= outstanding_d;
         aqHead_q      <= aqHead_d;
         aqTail_q      <= aqTail_d;
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         fifoCount_q   <= fifoCount_d;
         holdAddr_q    <= holdAddr_d;
         holdInst_q    <= holdInst_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         holdMis_q     <= holdMis_d;
`endif
      end
   end

   // Data storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (fifoPush) begin
         fifoAddr_q[wrPtr_q] <= pushAddr;
         fifoInst_q[wrPtr_q] <= pushInst;
`ifdef FETCH_MISALIGN_CHECK_EN
         fifoMis_q[wrPtr_q]  <= misPush;
`endif
      end
      if (reqFire) aqAddr_q[aqTail_q] <= bus.pc_addr;
   end

   assign bus.pc_stall       = pcStall;
   assign bus.imem_req_valid = reqValid;
   assign bus.imem_req_addr  = bus.pc_addr;
   assign bus.out_valid      = !fifoEmpty;
   assign bus.out_addr       = fifoEmpty ? holdAddr_q : fifoAddr_q[rdPtr_q];
   assign bus.out_inst       = fifoEmpty ? holdInst_q : fifoInst_q[rdPtr_q];
`ifdef FETCH_MISALIGN_CHECK_EN
   assign bus.out_misalign   = fifoEmpty ? holdMis_q : fifoMis_q[rdPtr_q];
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed self-checking bench for inst_fetch_queue. The bench plays the PC
// (advance by 4 unless stalled, load target on redirect), an in-order memory
// with programmable latency, and the decode consumer. Inputs are driven on
// the falling edge and outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;
   localparam int AW = 32;
   localparam int IW = 32;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   inst_fetch_queue_if #(.AW(AW), .IW(IW)) bus ();

   inst_fetch_queue #(
      .INST_MEMORY_ADDRESS_WIDTH(AW),
      .INST_WIDTH(IW),
      .QUEUE_DEPTH(4),
      .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc;
   int lat;
   int reqCount;
   int firstReqCyc;
   int maxInflight;
   logic [31:0] pc;
   logic [31:0] pendAddr[$];
   int          pendDue[$];
   logic [31:0] gotAddr[$];
   logic [31:0] gotInst[$];
   int          gotCyc[$];

   logic        obsReqValid, obsStall, obsOutValid, obsRsp;
   logic [31:0] obsReqAddr, obsOutAddr, obsOutInst;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        obsOutMis;
`endif

   // Contents of instruction memory at a given address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'hA500_0000 ^ (a * 3 + 32'h11);
   endfunction

   // Runs one clock cycle: present inputs, sample outputs, update the models.
   task automatic cycle(input logic redir, input logic [31:0] target);
      bus.redirect = redir;
      bus.pc_addr  = pc;
      if (pendAddr.size() != 0 && pendDue[0] <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = memWord(pendAddr[0]);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'hDEAD_BEEF;
      end
      #1;
      obsReqValid = bus.imem_req_valid;
      obsReqAddr  = bus.imem_req_addr;
      obsStall    = bus.pc_stall;
      obsOutValid = bus.out_valid;
      obsOutAddr  = bus.out_addr;
      obsOutInst  = bus.out_inst;
      obsRsp      = bus.imem_rsp_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
      obsOutMis   = bus.out_misalign;
`endif
      if (obsRsp) begin
         pendAddr.delete(0);
         pendDue.delete(0);
      end
      if (obsReqValid && bus.imem_req_ready) begin
         pendAddr.push_back(obsReqAddr);
         pendDue.push_back(cyc + lat);
         reqCount++;
         if (firstReqCyc < 0) firstReqCyc = cyc;
      end
      if (pendAddr.size() > maxInflight) maxInflight = pendAddr.size();
      if (obsOutValid && bus.out_ready && !redir) begin
         gotAddr.push_back(obsOutAddr);
         gotInst.push_back(obsOutInst);
         gotCyc.push_back(cyc);
      end
      if (redir)          pc = target;
      else if (!obsStall) pc = pc + 32'd4;
      @(negedge clk);
      cyc++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
   endtask

   task automatic clearObserved();
      gotAddr.delete();
      gotInst.delete();
      gotCyc.delete();
   endtask

   // Resets the DUT and the memory model together.
   task automatic doReset();
      rst_n              = 1'b0;
      bus.redirect       = 1'b0;
      bus.pc_addr        = 32'h0;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.out_ready      = 1'b0;
      pendAddr.delete();
      pendDue.delete();
      clearObserved();
      @(negedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      cyc         = 0;
      reqCount    = 0;
      firstReqCyc = -1;
      maxInflight = 0;
   endtask

   task automatic test_reset();
      rst_n              = 1'b0;
      bus.redirect       = 1'b0;
      bus.pc_addr        = 32'h40;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'h1234_5678;
      bus.out_ready      = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks += 5;
      if (bus.pc_stall !== 1'b1) begin failures++; $display("[TB] FAIL reset_pc_stall got=%b exp=1", bus.pc_stall); end
      if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
      if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      if (bus.out_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_addr got=%h exp=0", bus.out_addr); end
      if (bus.out_inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_inst got=%h exp=0", bus.out_inst); end
   endtask

   task automatic test_basic();
      doReset();
      lat = 1; pc = 32'h0; bus.out_ready = 1'b1;
      runCycles(6);
      checks += 2;
      if (firstReqCyc !== 0) begin failures++; $display("[TB] FAIL basic_first_req got=%0d exp=0", firstReqCyc); end
      if (gotCyc.size() < 3) begin
         failures++; $display("[TB] FAIL basic_out_count got=%0d exp>=3", gotCyc.size());
      end else begin
         if (gotCyc[0] - firstReqCyc !== 2) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=2", gotCyc[0] - firstReqCyc); end
         checks += 5;
         if (gotAddr[0] !== 32'h0 || gotInst[0] !== memWord(32'h0)) begin failures++; $display("[TB] FAIL basic_out0 got=(%h,%h) exp=(0,%h)", gotAddr[0], gotInst[0], memWord(32'h0)); end
         if (gotAddr[1] !== 32'h4 || gotInst[1] !== memWord(32'h4)) begin failures++; $display("[TB] FAIL basic_out1 got=(%h,%h) exp=(4,%h)", gotAddr[1], gotInst[1], memWord(32'h4)); end
         if (gotAddr[2] !== 32'h8 || gotInst[2] !== memWord(32'h8)) begin failures++; $display("[TB] FAIL basic_out2 got=(%h,%h) exp=(8,%h)", gotAddr[2], gotInst[2], memWord(32'h8)); end
         if (gotCyc[2] - gotCyc[0] !== 2) begin failures++; $display("[TB] FAIL basic_back_to_back got=%0d exp=2", gotCyc[2] - gotCyc[0]); end
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      lat = 1; pc = 32'h0; bus.out_ready = 1'b0;
      runCycles(4);
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out_valid got=%b exp=0", bus.out_valid); end
      if (bus.out_addr !== 32'h0) begin failures++; $display("[TB] FAIL midreset_out_addr got=%h exp=0", bus.out_addr); end
      if (bus.pc_stall !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pc_stall got=%b exp=1", bus.pc_stall); end
      if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_req_valid got=%b exp=0", bus.imem_req_valid); end
   endtask

   task automatic test_backpressure();
      doReset();
      lat = 1; pc = 32'h0; bus.out_ready = 1'b0;
      runCycles(10);
      checks += 4;
      if (reqCount !== 4) begin failures++; $display("[TB] FAIL bp_req_total got=%0d exp=4", reqCount); end
      if (obsStall !== 1'b1) begin failures++; $display("[TB] FAIL bp_pc_stall got=%b exp=1", obsStall); end
      if (obsOutValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_out_valid got=%b exp=1", obsOutValid); end
      if (obsOutAddr !== 32'h0) begin failures++; $display("[TB] FAIL bp_head_addr got=%h exp=0", obsOutAddr); end
      bus.out_ready = 1'b1;
      runCycles(1);
      bus.out_ready = 1'b0;
      runCycles(5);
      checks += 2;
      if (reqCount !== 5) begin failures++; $display("[TB] FAIL bp_one_pop_req got=%0d exp=5", reqCount); end
      if (gotAddr.size() !== 1 || gotAddr[0] !== 32'h0) begin failures++; $display("[TB] FAIL bp_first_pop count=%0d exp=1 addr0", gotAddr.size()); end
      bus.out_ready = 1'b1;
      runCycles(2);
      bus.out_ready = 1'b0;
      runCycles(5);
      checks += 2;
      if (reqCount !== 7) begin failures++; $display("[TB] FAIL bp_two_pop_req got=%0d exp=7", reqCount); end
      if (pc !== 32'h1C) begin failures++; $display("[TB] FAIL bp_pc got=%h exp=1c", pc); end
   endtask

   task automatic test_latency3();
      doReset();
      lat = 3; pc = 32'h10; bus.out_ready = 1'b1;
      runCycles(20);
      checks += 2;
      if (maxInflight !== 2) begin failures++; $display("[TB] FAIL lat3_inflight got=%0d exp=2", maxInflight); end
      if (gotAddr.size() < 3) begin
         failures++; $display("[TB] FAIL lat3_out_count got=%0d exp>=3", gotAddr.size());
      end else begin
         checks += 3;
         if (gotAddr[0] !== 32'h10 || gotInst[0] !== memWord(32'h10)) begin failures++; $display("[TB] FAIL lat3_pair0 got=(%h,%h) exp=(10,%h)", gotAddr[0], gotInst[0], memWord(32'h10)); end
         if (gotAddr[1] !== 32'h14 || gotInst[1] !== memWord(32'h14)) begin failures++; $display("[TB] FAIL lat3_pair1 got=(%h,%h) exp=(14,%h)", gotAddr[1], gotInst[1], memWord(32'h14)); end
         if (gotAddr[2] !== 32'h18 || gotInst[2] !== memWord(32'h18)) begin failures++; $display("[TB] FAIL lat3_pair2 got=(%h,%h) exp=(18,%h)", gotAddr[2], gotInst[2], memWord(32'h18)); end
      end
   endtask

   task automatic test_redirect();
      int reqBefore;
      doReset();
      lat = 1; pc = 32'h0; bus.out_ready = 1'b0;
      runCycles(1);
      lat = 5;
      runCycles(2);
      checks += 1;
      if (obsOutValid !== 1'b1 || obsOutAddr !== 32'h0) begin failures++; $display("[TB] FAIL redir_pre_head got=(%b,%h) exp=(1,0)", obsOutValid, obsOutAddr); end
      cycle(1'b1, 32'h100);
      checks += 2;
      if (obsStall !== 1'b0) begin failures++; $display("[TB] FAIL redir_pc_stall got=%b exp=0", obsStall); end
      if (obsReqValid !== 1'b0) begin failures++; $display("[TB] FAIL redir_req_valid got=%b exp=0", obsReqValid); end
      lat = 1; bus.out_ready = 1'b1;
      clearObserved();
      reqBefore = reqCount;
      runCycles(1);
      checks += 2;
      if (obsOutValid !== 1'b0) begin failures++; $display("[TB] FAIL redir_fifo_empty got=%b exp=0", obsOutValid); end
      if (obsStall !== 1'b1) begin failures++; $display("[TB] FAIL redir_flush_stall got=%b exp=1", obsStall); end
      runCycles(3);
      checks += 1;
      if (reqCount !== reqBefore) begin failures++; $display("[TB] FAIL redir_flush_no_req got=%0d exp=%0d", reqCount - reqBefore, 0); end
      runCycles(1);
      checks += 1;
      if (obsReqValid !== 1'b1 || obsReqAddr !== 32'h100) begin failures++; $display("[TB] FAIL redir_target_req got=(%b,%h) exp=(1,100)", obsReqValid, obsReqAddr); end
      runCycles(5);
      checks += 1;
      if (gotAddr.size() == 0) begin
         failures++; $display("[TB] FAIL redir_first_out got=none exp=(100,%h)", memWord(32'h100));
      end else if (gotAddr[0] !== 32'h100 || gotInst[0] !== memWord(32'h100)) begin
         failures++; $display("[TB] FAIL redir_first_out got=(%h,%h) exp=(100,%h)", gotAddr[0], gotInst[0], memWord(32'h100));
      end
   endtask

   task automatic test_redirect_last_rsp();
      doReset();
      lat = 2; pc = 32'h0; bus.out_ready = 1'b1;
      runCycles(3);
      cycle(1'b1, 32'h200);
      checks += 1;
      if (obsStall !== 1'b0) begin failures++; $display("[TB] FAIL lastrsp_pc_stall got=%b exp=0", obsStall); end
      clearObserved();
      runCycles(1);
      checks += 2;
      if (obsReqValid !== 1'b1 || obsReqAddr !== 32'h200) begin failures++; $display("[TB] FAIL lastrsp_target_req got=(%b,%h) exp=(1,200)", obsReqValid, obsReqAddr); end
      if (obsOutValid !== 1'b0) begin failures++; $display("[TB] FAIL lastrsp_dropped got=%b exp=0", obsOutValid); end
      runCycles(5);
      checks += 1;
      if (gotAddr.size() == 0) begin
         failures++; $display("[TB] FAIL lastrsp_first_out got=none exp=(200,%h)", memWord(32'h200));
      end else if (gotAddr[0] !== 32'h200 || gotInst[0] !== memWord(32'h200)) begin
         failures++; $display("[TB] FAIL lastrsp_first_out got=(%h,%h) exp=(200,%h)", gotAddr[0], gotInst[0], memWord(32'h200));
      end
   endtask

`ifdef FETCH_MISALIGN_CHECK_EN
   task automatic test_misalign();
      doReset();
      lat = 1; pc = 32'h102; bus.out_ready = 1'b1;
      runCycles(1);
      checks += 2;
      if (obsReqValid !== 1'b0) begin failures++; $display("[TB] FAIL mis_req_valid got=%b exp=0", obsReqValid); end
      if (obsStall !== 1'b0) begin failures++; $display("[TB] FAIL mis_pc_stall got=%b exp=0", obsStall); end
      runCycles(1);
      checks += 1;
      if (obsOutValid !== 1'b1 || obsOutAddr !== 32'h102 || obsOutInst !== 32'h0 || obsOutMis !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mis_entry got=(%b,%h,%h,%b) exp=(1,102,0,1)", obsOutValid, obsOutAddr, obsOutInst, obsOutMis);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_reset_mid();
      test_backpressure();
      test_latency3();
      test_redirect();
      test_redirect_last_rsp();
`ifdef FETCH_MISALIGN_CHECK_EN
      test_misalign();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
